// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter granting one of NREQ requesters a write into a shared W-bit register.
// Latency: req at edge E -> gnt after E -> q/q_valid after E+1 -> rearbitrate at E+3; no backpressure, a winner may withdraw during GRANT.
module reg_write_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*W-1:0]   wdata,
    output logic [NREQ-1:0]     gnt,
    output logic [W-1:0]        q,
    output logic                q_valid,
    output logic                busy,
    output logic [15:0]         wr_count
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, GRANT, COMMIT} state_t;

    state_t          state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   winner;
    logic [PW-1:0]   pick;
    logic            found;
    logic [W-1:0]    slice [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_slice
        assign slice[i] = wdata[i*W +: W];
    end

    // First set request at or above ptr, wrapping around the top.
    always_comb begin
        int j;
        j     = 0;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(ptr) + k) % NREQ;
            if (!found && req[PW'(j)]) begin
                found = 1'b1;
                pick  = PW'(j);
            end
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            gnt      <= '0;
            q        <= '0;
            q_valid  <= 1'b0;
            ptr      <= '0;
            winner   <= '0;
            wr_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    q_valid <= 1'b0;
                    gnt     <= '0;
                    if (found) begin
                        gnt[pick] <= 1'b1;
                        winner    <= pick;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    gnt <= '0;
                    if (req[winner]) begin
                        q       <= slice[winner];
                        q_valid <= 1'b1;
                        state   <= COMMIT;
                    end else begin
                        // Withdrawn winner: no write, pointer keeps its place.
                        state <= IDLE;
                    end
                end
                COMMIT: begin
                    q_valid  <= 1'b0;
                    ptr      <= (winner == PW'(NREQ - 1)) ? '0 : winner + PW'(1);
                    wr_count <= wr_count + 16'd1;
                    state    <= IDLE;
                end
                default: begin
                    gnt     <= '0;
                    q_valid <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: directed scenarios plus random transactions against a round-robin model.
module tb_reg_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] wdata;
    logic [3:0]  gnt;
    logic [7:0]  q;
    logic        q_valid;
    logic        busy;
    logic [15:0] wr_count;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    // Reference model state
    int          m_ptr;
    logic [7:0]  m_q;
    int unsigned m_cnt;

    reg_write_arbiter #(.NREQ(4), .W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .wdata    (wdata),
        .gnt      (gnt),
        .q        (q),
        .q_valid  (q_valid),
        .busy     (busy),
        .wr_count (wr_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("check %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick_winner(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++)
            if (r[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = 0;
        m_q   = 8'h00;
        m_cnt = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"},   32'(gnt),      0);
        check({tag, "_q"},     32'(q),        0);
        check({tag, "_qv"},    32'(q_valid),  0);
        check({tag, "_busy"},  32'(busy),     0);
        check({tag, "_cnt"},   32'(wr_count), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        req = 4'b0000;
        #1 check_all_zero("rst");
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    // One arbitration round starting at a negedge with the DUT idle.
    task automatic txn(input logic [3:0] r, input logic [31:0] d, input bit withdraw, input string tag);
        int          w;
        logic [3:0]  r2;
        logic [31:0] d2;
        req   = r;
        wdata = d;
        w     = pick_winner(r, m_ptr);
        @(negedge clk);
        if (w < 0) begin
            check({tag, "_idle_gnt"},  32'(gnt),  0);
            check({tag, "_idle_busy"}, 32'(busy), 0);
            req = 4'b0000;
            return;
        end
        check({tag, "_gnt"},      32'(gnt),     1 << w);
        check({tag, "_g_busy"},   32'(busy),    1);
        check({tag, "_g_qv"},     32'(q_valid), 0);
        check({tag, "_g_q"},      32'(q),       32'(m_q));
        // Disturb every input except the winner's own data.
        r2 = 4'($urandom);
        d2 = $urandom;
        r2[w] = !withdraw;
        d2[w*8 +: 8] = d[w*8 +: 8];
        req   = r2;
        wdata = d2;
        @(negedge clk);
        if (withdraw) begin
            check({tag, "_wd_gnt"},  32'(gnt),     0);
            check({tag, "_wd_q"},    32'(q),       32'(m_q));
            check({tag, "_wd_qv"},   32'(q_valid), 0);
            check({tag, "_wd_busy"}, 32'(busy),    0);
            req = 4'b0000;
            return;
        end
        m_q = d[w*8 +: 8];
        check({tag, "_c_q"},    32'(q),       32'(m_q));
        check({tag, "_c_qv"},   32'(q_valid), 1);
        check({tag, "_c_gnt"},  32'(gnt),     0);
        check({tag, "_c_busy"}, 32'(busy),    1);
        req   = 4'($urandom);
        wdata = $urandom;
        @(negedge clk);
        m_ptr = (w + 1) % 4;
        m_cnt = (m_cnt + 1) % 65536;
        check({tag, "_e_qv"},   32'(q_valid),  0);
        check({tag, "_e_cnt"},  32'(wr_count), m_cnt);
        check({tag, "_e_q"},    32'(q),        32'(m_q));
        check({tag, "_e_busy"}, 32'(busy),     0);
        req = 4'b0000;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b0;
        req   = 4'b0000;
        wdata = 32'h0;
        model_reset();
        #1 check_all_zero("por");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("idle_gnt",  32'(gnt),  0);
        check("idle_busy", 32'(busy), 0);

        // Single requester
        txn(4'b0001, 32'h000000A5, 1'b0, "single");
        check("single_q",   32'(q),        32'hA5);
        check("single_cnt", 32'(wr_count), 1);

        // Fairness with all requesters active
        do_reset();
        for (int i = 0; i < 4; i++) txn(4'b1111, 32'h44332211, 1'b0, "rr");
        check("rr_cnt", 32'(wr_count), 4);
        check("rr_q",   32'(q),        32'h44);

        // Withdrawal leaves pointer alone
        do_reset();
        txn(4'b0100, 32'h00C30000, 1'b1, "wd");
        check("wd_ptr", 32'(dut.ptr), 32'(m_ptr));
        txn(4'b0101, 32'h00770088, 1'b0, "wd_next");
        check("wd_next_q", 32'(q), 32'h88);

        // Wrap-around search
        txn(4'b0100, 32'h00110000, 1'b0, "wrap_a");
        check("wrap_ptr", 32'(dut.ptr), 3);
        txn(4'b0001, 32'h0000005A, 1'b0, "wrap_b");
        check("wrap_b_q", 32'(q), 32'h5A);
        txn(4'b0100, 32'h00220000, 1'b0, "wrap_c");
        txn(4'b1001, 32'h3C0000C3, 1'b0, "wrap_d");
        check("wrap_d_q", 32'(q), 32'h3C);

        // Random traffic
        for (int i = 0; i < 40; i++)
            txn(4'($urandom), $urandom, ($urandom_range(0, 4) == 0), "rnd");

        // Asynchronous reset while granting
        @(negedge clk);
        req   = 4'b0010;
        wdata = 32'hFFFFFFFF;
        @(negedge clk);
        check("arst_gnt_before", 32'(gnt), 32'h2);
        #2 rst = 1'b0;
        #1 check_all_zero("arst");
        model_reset();
        @(negedge clk);
        req = 4'b0000;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("arst_after_q",  32'(q),       0);
            check("arst_after_qv", 32'(q_valid), 0);
        end

        // Counter wrap
        force dut.wr_count = 16'hFFFF;
        @(negedge clk);
        release dut.wr_count;
        m_cnt = 32'hFFFF;
        check("wrap_preload", 32'(wr_count), 32'hFFFF);
        txn(4'b1000, 32'h69000000, 1'b0, "cntwrap");
        check("cntwrap_cnt", 32'(wr_count), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 Parameter NREQ, default 4, SHALL be the number of requesters sharing the D-register bank (fixed 4 in this revision).
REQ-002 Parameter W, default 8, SHALL be the width of the shared register.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 req  input  NREQ  SHALL carry the per-requester write requests; bit i belongs to requester i.
REQ-006 wdata  input  NREQ*W  SHALL carry the write data; slice [i*W +: W] belongs to requester i.
REQ-007 gnt  output  NREQ  SHALL be the one-hot grant, registered.
REQ-008 q  output  W  SHALL be the shared register contents, registered.
REQ-009 q_valid  output  1  SHALL be a one-cycle pulse marking a committed write.
REQ-010 busy  output  1  SHALL be high whenever the FSM is not in IDLE.
REQ-011 wr_count  output  16  SHALL count committed writes.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, GRANT, COMMIT.
REQ-013 IDLE: if req is nonzero at a clock edge, the FSM SHALL select one winner, set gnt to its one-hot code and enter GRANT; otherwise it SHALL stay in IDLE with gnt=0.
REQ-014 Winner selection SHALL be round-robin: the first set req bit searching upward from pointer ptr (2 bits), wrapping from NREQ-1 to 0.
REQ-015 GRANT, req[winner]=1: q SHALL load wdata slice of winner, gnt SHALL clear, FSM SHALL enter COMMIT.
REQ-016 GRANT, req[winner]=0 (withdrawn): gnt SHALL clear, q SHALL be unchanged, ptr SHALL be unchanged, no q_valid, FSM SHALL return to IDLE.
REQ-017 COMMIT: q_valid SHALL be 1 for exactly this cycle, ptr SHALL become (winner+1) mod NREQ, wr_count SHALL increment by 1, FSM SHALL return to IDLE unconditionally.
REQ-018 Latency SHALL be: req sampled at edge E -> gnt high after E -> q updated after E+1 -> q_valid high after E+1 for one cycle -> next arbitration sampled at edge E+3.
REQ-019 Requests arriving or changing while busy=1 SHALL be ignored except for the winner check in REQ-015/016.
REQ-020 Changes on non-winning wdata slices SHALL never affect q.
REQ-021 wr_count SHALL wrap from 16'hFFFF to 16'h0000 without saturation or flag.
REQ-022 gnt SHALL never have more than one bit set; gnt and q_valid SHALL never be high in the same cycle.
REQ-023 q SHALL change only on the GRANT->COMMIT transition.

Reset
REQ-024 rst=0 SHALL immediately, without waiting for clk, force state=IDLE, gnt=0, q=0, q_valid=0, busy=0, ptr=0, wr_count=0.
REQ-025 Reset asserted mid-transaction (GRANT or COMMIT) SHALL abort it with no write and no q_valid after release.
REQ-026 After rst rises, the first arbitration SHALL occur at the first clk rising edge with req nonzero.

Verification
REQ-027 Single request: after reset, req=4'b0001, wdata[7:0]=8'hA5 held -> gnt=0001 one cycle, q=8'hA5 next cycle with q_valid=1 one cycle, wr_count=1.
REQ-028 Round-robin fairness: req=4'b1111 held for 12 cycles, distinct wdata per slice -> grants in order 0,1,2,3 repeating, each write 3 cycles apart, wr_count=4 after 12 cycles.
REQ-029 Withdrawal: req=4'b0100, drop req[2] in GRANT cycle -> gnt clears, q unchanged, no q_valid, ptr=0, next req=4'b0101 grants requester 0.
REQ-030 Wrap search: ptr=3 after a write by requester 2, req=4'b0001 -> requester 0 granted; req=4'b1001 -> requester 3 granted.
REQ-031 Async reset mid-GRANT: assert rst=0 between clock edges while gnt=0010 -> all outputs 0 immediately, q stays 0 after release, no q_valid.
REQ-032 Counter wrap: preload by 65535 commits (or force) then one more write -> wr_count=16'h0000, q_valid=1.
